uart_boot_loader: RTL and testbench



---
 rtl/uart_boot_loader_if.sv | 25 ++
 rtl/uart_boot_loader.sv | 162 ++++++++++++++++
 tb/tb_uart_boot_loader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_loader_if.sv
// Byte stream in from the UART receiver, RAM write port and load status out.
// master = boot loader side, slave = UART/RAM/core side.
interface uart_boot_loader_if #(
  parameter int ADDR_W = 13
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              mem_we;
  logic              core_start;
  logic              busy;
  logic [1:0]        err_code;
  logic [15:0]       words_loaded;

  modport master (
    input  rx_data, rx_valid,
    output mem_addr, mem_data, mem_we, core_start, busy, err_code, words_loaded
  );

  modport slave (
    output rx_data, rx_valid,
    input  mem_addr, mem_data, mem_we, core_start, busy, err_code, words_loaded
  );
endinterface

// File: rtl/uart_boot_loader.sv
// Loads a length-prefixed, checksummed program image from the UART byte stream
// into 32-bit RAM, then pulses core_start when the checksum is good.
module uart_boot_loader #(
  parameter int          ADDR_W         = 13,
  parameter int          BASE_ADDR      = 0,
  parameter logic [7:0]  SYNC_BYTE      = 8'hFF,
  parameter int          TIMEOUT_CYCLES = 600000
) (
  input logic               clk,
  input logic               rst_n,
  uart_boot_loader_if.master bus
);

  localparam int                TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_LEN0 = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM
  } state_t;

  state_t            state_reg;
  logic [15:0]       len_reg;
  logic [7:0]        csum_reg;
  logic [1:0]        lane_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [31:0]       mem_data_reg;
  logic              mem_we_reg;
  logic              core_start_reg;
  logic [1:0]        err_reg;
  logic [15:0]       words_reg;
  logic [TO_W-1:0]   tmo_reg;

  logic [7:0]        csum_next;
  logic              tmo_expire;

  assign csum_next  = csum_reg + bus.rx_data;
  assign tmo_expire = (state_reg != S_IDLE) && !bus.rx_valid && (tmo_reg == TO_LAST);

  // Lower three bytes of the word being assembled; the fourth byte goes
  // straight into mem_data alongside them.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    logic [7:0] byte_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        byte_reg <= 8'h00;
      end else if (state_reg == S_DATA && bus.rx_valid && lane_reg == 2'(gi)) begin
        byte_reg <= bus.rx_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      len_reg        <= 16'h0000;
      csum_reg       <= 8'h00;
      lane_reg       <= 2'd0;
      mem_addr_reg   <= BASE;
      mem_data_reg   <= 32'h0000_0000;
      mem_we_reg     <= 1'b0;
      core_start_reg <= 1'b0;
      err_reg        <= ERR_NONE;
      words_reg      <= 16'h0000;
      tmo_reg        <= '0;
    end else begin
      mem_we_reg     <= 1'b0;
      core_start_reg <= 1'b0;

      if (mem_we_reg) begin
        mem_addr_reg <= mem_addr_reg + 1'b1;
      end

      if (state_reg == S_IDLE || bus.rx_valid) begin
        tmo_reg <= '0;
      end else begin
        tmo_reg <= tmo_reg + 1'b1;
      end

      // A byte arriving in the expiry cycle takes priority over the timeout.
      if (tmo_expire) begin
        state_reg <= S_IDLE;
        err_reg   <= ERR_TMO;
      end else if (bus.rx_valid) begin
        case (state_reg)
          S_IDLE: begin
            if (bus.rx_data == SYNC_BYTE) begin
              state_reg    <= S_LEN_HI;
              err_reg      <= ERR_NONE;
              words_reg    <= 16'h0000;
              csum_reg     <= 8'h00;
              lane_reg     <= 2'd0;
              mem_addr_reg <= BASE;
            end
          end

          S_LEN_HI: begin
            len_reg[15:8] <= bus.rx_data;
            csum_reg      <= csum_next;
            state_reg     <= S_LEN_LO;
          end

          S_LEN_LO: begin
            len_reg[7:0] <= bus.rx_data;
            csum_reg     <= csum_next;
            if ({len_reg[15:8], bus.rx_data} == 16'h0000) begin
              state_reg <= S_IDLE;
              err_reg   <= ERR_LEN0;
            end else begin
              state_reg <= S_DATA;
            end
          end

          S_DATA: begin
            csum_reg <= csum_next;
            lane_reg <= lane_reg + 2'd1;
            if (lane_reg == 2'd3) begin
              mem_we_reg   <= 1'b1;
              mem_data_reg <= {bus.rx_data, g_lane[2].byte_reg,
                               g_lane[1].byte_reg, g_lane[0].byte_reg};
              if (words_reg != 16'hFFFF) begin
                words_reg <= words_reg + 16'd1;
              end
              if (words_reg == len_reg - 16'd1) begin
                state_reg <= S_CSUM;
              end
            end
          end

          S_CSUM: begin
            state_reg <= S_IDLE;
            if (csum_next == 8'h00) begin
              core_start_reg <= 1'b1;
            end else begin
              err_reg <= ERR_CSUM;
            end
          end

          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.mem_addr     = mem_addr_reg;
  assign bus.mem_data     = mem_data_reg;
  assign bus.mem_we       = mem_we_reg;
  assign bus.core_start   = core_start_reg;
  assign bus.busy         = (state_reg != S_IDLE);
  assign bus.err_code     = err_reg;
  assign bus.words_loaded = words_reg;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: two instances (base 0 and base 8190) share one
// byte stream; expected RAM writes are queued as bytes are sent.
module tb_uart_boot_loader;

  localparam int AW    = 13;
  localparam int TMO   = 40;
  localparam int BASE1 = 8190;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;

  always #5 clk = ~clk;

  uart_boot_loader_if #(.ADDR_W(AW)) bus0 ();
  uart_boot_loader_if #(.ADDR_W(AW)) bus1 ();

  assign bus0.rx_data  = rx_data;
  assign bus0.rx_valid = rx_valid;
  assign bus1.rx_data  = rx_data;
  assign bus1.rx_valid = rx_valid;

  uart_boot_loader #(
    .ADDR_W(AW), .BASE_ADDR(0), .SYNC_BYTE(8'hFF), .TIMEOUT_CYCLES(TMO)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  uart_boot_loader #(
    .ADDR_W(AW), .BASE_ADDR(BASE1), .SYNC_BYTE(8'hFF), .TIMEOUT_CYCLES(TMO)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  int          checks_cnt = 0;
  int          errors_cnt = 0;
  int          starts0 = 0;
  int          starts1 = 0;
  int          exp_starts = 0;
  logic [44:0] exp_q0[$];
  logic [44:0] exp_q1[$];
  logic [7:0]  pay_q[$];
  logic [44:0] e0;
  logic [44:0] e1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every write and start pulse is checked as it appears.
  always @(negedge clk) begin
    if (bus0.mem_we) begin
      chk("dut0_we_expected", 64'(exp_q0.size() != 0), 64'(1));
      if (exp_q0.size() != 0) begin
        e0 = exp_q0.pop_front();
        chk("dut0_addr", 64'(bus0.mem_addr), 64'(e0[44:32]));
        chk("dut0_data", 64'(bus0.mem_data), 64'(e0[31:0]));
        $display("write dut0 addr=%0d data=%08h", bus0.mem_addr, bus0.mem_data);
      end
    end
    if (bus1.mem_we) begin
      chk("dut1_we_expected", 64'(exp_q1.size() != 0), 64'(1));
      if (exp_q1.size() != 0) begin
        e1 = exp_q1.pop_front();
        chk("dut1_addr", 64'(bus1.mem_addr), 64'(e1[44:32]));
        chk("dut1_data", 64'(bus1.mem_data), 64'(e1[31:0]));
        $display("write dut1 addr=%0d data=%08h", bus1.mem_addr, bus1.mem_data);
      end
    end
    if (bus0.core_start) begin
      starts0++;
      chk("dut0_busy_at_start", 64'(bus0.busy), 64'(0));
    end
    if (bus1.core_start) begin
      starts1++;
      chk("dut1_busy_at_start", 64'(bus1.busy), 64'(0));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic tx(input logic [7:0] b, input bit b2b);
    put(b);
    if (!b2b) gap(1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_addr0"},  64'(bus0.mem_addr), 64'(0));
    chk({tag, "_addr1"},  64'(bus1.mem_addr), 64'(BASE1));
    chk({tag, "_data0"},  64'(bus0.mem_data), 64'(0));
    chk({tag, "_we0"},    64'(bus0.mem_we), 64'(0));
    chk({tag, "_start0"}, 64'(bus0.core_start), 64'(0));
    chk({tag, "_busy0"},  64'(bus0.busy), 64'(0));
    chk({tag, "_err0"},   64'(bus0.err_code), 64'(0));
    chk({tag, "_words0"}, 64'(bus0.words_loaded), 64'(0));
    chk({tag, "_busy1"},  64'(bus1.busy), 64'(0));
  endtask

  task automatic check_status(input string tag, input logic [1:0] err, input logic [15:0] words);
    chk({tag, "_busy0"},   64'(bus0.busy), 64'(0));
    chk({tag, "_busy1"},   64'(bus1.busy), 64'(0));
    chk({tag, "_err0"},    64'(bus0.err_code), 64'(err));
    chk({tag, "_err1"},    64'(bus1.err_code), 64'(err));
    chk({tag, "_words0"},  64'(bus0.words_loaded), 64'(words));
    chk({tag, "_words1"},  64'(bus1.words_loaded), 64'(words));
    chk({tag, "_starts0"}, 64'(starts0), 64'(exp_starts));
    chk({tag, "_starts1"}, 64'(starts1), 64'(exp_starts));
    $display("frame %s err=%0d words=%0d starts=%0d", tag, bus0.err_code,
             bus0.words_loaded, starts0);
  endtask

  // Sends SYNC, LEN, pay_q and CS; abort_after >= 0 stops after that many payload bytes.
  task automatic send_frame(input bit bad_cs, input bit b2b, input int abort_after);
    logic [15:0] len;
    logic [7:0]  sum;
    logic [31:0] w;
    int          n;
    n   = pay_q.size();
    len = 16'(n / 4);
    sum = len[15:8] + len[7:0];
    tx(8'hFF, b2b);
    tx(len[15:8], b2b);
    tx(len[7:0], b2b);
    for (int i = 0; i < n; i++) begin
      if (abort_after >= 0 && i == abort_after) break;
      if (i % 4 == 3) begin
        w = {pay_q[i], pay_q[i-1], pay_q[i-2], pay_q[i-3]};
        exp_q0.push_back({13'(i / 4), w});
        exp_q1.push_back({13'(BASE1 + i / 4), w});
      end
      sum = sum + pay_q[i];
      tx(pay_q[i], b2b);
    end
    if (abort_after >= 0) begin
      gap(1);
      return;
    end
    tx(8'h00 - sum + (bad_cs ? 8'h01 : 8'h00), b2b);
    gap(3);
    if (!bad_cs) exp_starts++;
  endtask

  task automatic random_payload(input int words);
    pay_q.delete();
    for (int i = 0; i < words * 4; i++) pay_q.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    gap(2);

    pay_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_frame(1'b0, 1'b0, -1);
    check_status("good", 2'b00, 16'd2);

    send_frame(1'b1, 1'b0, -1);
    check_status("bad_cs", 2'b01, 16'd2);

    tx(8'hFF, 1'b0); tx(8'h00, 1'b0); tx(8'h01, 1'b0);
    tx(8'hAA, 1'b0); tx(8'hBB, 1'b0); tx(8'hCC, 1'b0);
    gap(TMO - 5);
    chk("tmo_busy_before", 64'(bus0.busy), 64'(1));
    gap(10);
    check_status("timeout", 2'b10, 16'd0);

    random_payload(2);
    send_frame(1'b0, 1'b0, -1);
    check_status("after_tmo", 2'b00, 16'd2);

    tx(8'hFF, 1'b0); tx(8'h00, 1'b0); tx(8'h00, 1'b0);
    gap(3);
    check_status("zero_len", 2'b11, 16'd0);

    tx(8'h00, 1'b0); tx(8'h12, 1'b0);
    gap(2);
    chk("junk_busy", 64'(bus0.busy), 64'(0));
    chk("junk_err_sticky", 64'(bus0.err_code), 64'(2'b11));
    random_payload(1);
    send_frame(1'b0, 1'b0, -1);
    check_status("after_junk", 2'b00, 16'd1);

    random_payload(3);
    send_frame(1'b0, 1'b0, -1);
    check_status("wrap", 2'b00, 16'd3);

    random_payload(4);
    send_frame(1'b0, 1'b0, 5);
    chk("abort_busy_pre", 64'(bus0.busy), 64'(1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    gap(2);
    check_status("after_rst", 2'b00, 16'd0);

    random_payload(4);
    send_frame(1'b0, 1'b0, -1);
    check_status("post_rst", 2'b00, 16'd4);

    random_payload(5);
    send_frame(1'b0, 1'b1, -1);
    check_status("b2b", 2'b00, 16'd5);

    chk("q0_drained", 64'(exp_q0.size()), 64'(0));
    chk("q1_drained", 64'(exp_q1.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
